// File: rtl/stage_mem_access_if.sv
// Bundle of the execute, data-cache and writeback signals of the memory stage.
// The stage uses the slave view; the surrounding pipeline/bench uses the master view.
interface stage_mem_access_if;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic [31:0] ex_alu_result;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_mbe;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_err;
    logic        mem_timeout;

    modport slave (
        input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_rd_we, data_rdata, data_resp,
        output ex_ready, data_read, data_write, data_addr, data_mbe, data_wdata,
               wb_valid, wb_we, wb_rd, wb_data, mem_err, mem_timeout
    );

    modport master (
        output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_addr, ex_store_data,
               ex_alu_result, ex_rd, ex_rd_we, data_rdata, data_resp,
        input  ex_ready, data_read, data_write, data_addr, data_mbe, data_wdata,
               wb_valid, wb_we, wb_rd, wb_data, mem_err, mem_timeout
    );
endinterface

// File: rtl/stage_mem_access.sv
// RV32I memory stage: issues one data-cache access per load/store, aligns load
// data, builds store lanes/byte enables and emits one writeback pulse per instruction.
module stage_mem_access #(
    parameter int MAX_WAIT = 0
) (
    input  logic                clk,
    input  logic                rst,
    stage_mem_access_if.slave   bus
);
    typedef enum logic {IDLE, ACCESS} state_e;

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    mbe_q, mbe_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          is_load_q, is_load_d;
    logic [4:0]    rd_q, rd_d;
    logic          we_q, we_d;
    logic          wb_valid_q, wb_valid_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          mem_err_q, mem_err_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic          is_mem, legal_f3, misaligned, bad_op, timeout_hit;
    logic [31:0]   lane;
    logic [31:0]   load_val;

    always_comb begin
        is_mem = bus.ex_is_load | bus.ex_is_store;
        legal_f3 = 1'b0;
        case (bus.ex_funct3)
            3'b000, 3'b001, 3'b010: legal_f3 = 1'b1;
            3'b100, 3'b101:         legal_f3 = bus.ex_is_load;
            default:                legal_f3 = 1'b0;
        endcase
        misaligned = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_addr[0]) ||
                     ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_addr[1:0] != 2'b00));
        // A load that is also flagged as a store has no defined meaning.
        bad_op = is_mem & ((bus.ex_is_load & bus.ex_is_store) | ~legal_f3 | misaligned);
    end

    always_comb begin
        lane = bus.data_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_val = {24'd0, lane[7:0]};
            3'b101:  load_val = {16'd0, lane[15:0]};
            default: load_val = bus.data_rdata;
        endcase
    end

    assign timeout_hit = (MAX_WAIT != 0) && (wait_q == CW'(MAX_WAIT - 1));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mbe_d         = mbe_q;
        funct3_d      = funct3_q;
        is_load_d     = is_load_q;
        rd_d          = rd_q;
        we_d          = we_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        mem_err_d     = 1'b0;
        mem_timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = bus.ex_rd_we & (bus.ex_rd != 5'd0);
                        wb_rd_d    = bus.ex_rd;
                        wb_data_d  = bus.ex_alu_result;
                    end else if (bad_op) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.ex_rd;
                        wb_data_d  = 32'd0;
                        mem_err_d  = 1'b1;
                    end else begin
                        state_d   = ACCESS;
                        wait_d    = '0;
                        addr_d    = bus.ex_addr;
                        funct3_d  = bus.ex_funct3;
                        is_load_d = bus.ex_is_load;
                        rd_d      = bus.ex_rd;
                        we_d      = bus.ex_rd_we & (bus.ex_rd != 5'd0);
                        if (bus.ex_is_load) begin
                            mbe_d   = 4'b0000;
                            wdata_d = 32'd0;
                        end else begin
                            wdata_d = bus.ex_store_data << {bus.ex_addr[1:0], 3'b000};
                            case (bus.ex_funct3[1:0])
                                2'b00:   mbe_d = 4'b0001 << bus.ex_addr[1:0];
                                2'b01:   mbe_d = 4'b0011 << bus.ex_addr[1:0];
                                default: mbe_d = 4'b1111;
                            endcase
                        end
                    end
                end
            end
            ACCESS: begin
                if (bus.data_resp) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = is_load_q & we_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = is_load_q ? load_val : 32'd0;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = rd_q;
                    wb_data_d     = 32'd0;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            mbe_q         <= 4'd0;
            funct3_q      <= 3'd0;
            is_load_q     <= 1'b0;
            rd_q          <= 5'd0;
            we_q          <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= 32'd0;
            mem_err_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mbe_q         <= mbe_d;
            funct3_q      <= funct3_d;
            is_load_q     <= is_load_d;
            rd_q          <= rd_d;
            we_q          <= we_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            mem_err_q     <= mem_err_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Requests decode straight from the state register so an async reset kills them at once.
    assign bus.ex_ready    = (state_q == IDLE);
    assign bus.data_read   = (state_q == ACCESS) &  is_load_q;
    assign bus.data_write  = (state_q == ACCESS) & ~is_load_q;
    assign bus.data_addr   = {addr_q[31:2], 2'b00};
    assign bus.data_mbe    = mbe_q;
    assign bus.data_wdata  = wdata_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_we       = wb_we_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.mem_timeout = mem_timeout_q;
endmodule

// File: tb/tb_stage_mem_access.sv
// Directed bench for stage_mem_access (MAX_WAIT=4): writeback results go through
// an expectation queue checked by a monitor; bus-level values are checked inline.
module tb_stage_mem_access;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_mem_access_if bus ();
    stage_mem_access #(.MAX_WAIT(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for exactly one cycle (stage is known to be IDLE).
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] alu, input logic [4:0] rd, input logic we);
        bus.ex_valid      = 1'b1;
        bus.ex_is_load    = ld;
        bus.ex_is_store   = st;
        bus.ex_funct3     = f3;
        bus.ex_addr       = addr;
        bus.ex_store_data = sdata;
        bus.ex_alu_result = alu;
        bus.ex_rd         = rd;
        bus.ex_rd_we      = we;
        tick();
        bus.ex_valid = 1'b0;
    endtask

    task automatic push(input logic we, input logic [4:0] rd, input logic [31:0] data,
                        input logic err, input logic tmo);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data; e.err = err; e.tmo = tmo;
        sb_q.push_back(e);
    endtask

    // Scoreboard: every writeback pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
                check("wb_err", {31'd0, bus.mem_err}, {31'd0, e.err});
                check("wb_tmo", {31'd0, bus.mem_timeout}, {31'd0, e.tmo});
                if (e.we) begin
                    check("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
                    check("wb_data", bus.wb_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [2:0]  ld_f3[5]   = '{3'd4, 3'd0, 3'd1, 3'd5, 3'd2};
    logic [31:0] ld_addr[5] = '{32'h11, 32'h10, 32'h12, 32'h12, 32'h14};
    logic [31:0] ld_rdat[5] = '{32'h1234_80F0, 32'h0000_0085, 32'h8001_0000,
                                32'h8765_4321, 32'hDEAD_BEEF};
    logic [31:0] ld_exp[5]  = '{32'h0000_0080, 32'hFFFF_FF85, 32'hFFFF_8001,
                                32'h0000_8765, 32'hDEAD_BEEF};
    logic [2:0]  st_f3[4]   = '{3'd0, 3'd0, 3'd2, 3'd1};
    logic [31:0] st_addr[4] = '{32'h31, 32'h33, 32'h34, 32'h20};
    logic [31:0] st_dat[4]  = '{32'h1234_5655, 32'h0000_00AB, 32'hCAFE_F00D, 32'h0000_BEEF};
    logic [3:0]  st_mbe[4]  = '{4'b0010, 4'b1000, 4'b1111, 4'b0011};
    logic [31:0] st_wd[4]   = '{32'h3456_5500, 32'hAB00_0000, 32'hCAFE_F00D, 32'h0000_BEEF};
    logic        er_ld[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        er_st[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  er_f3[5]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    logic [31:0] er_addr[5] = '{32'h3, 32'h2, 32'h0, 32'h0, 32'h0};

    initial begin
        bus.ex_valid = 1'b0; bus.ex_is_load = 1'b0; bus.ex_is_store = 1'b0;
        bus.ex_funct3 = 3'd0; bus.ex_addr = 32'd0; bus.ex_store_data = 32'd0;
        bus.ex_alu_result = 32'd0; bus.ex_rd = 5'd0; bus.ex_rd_we = 1'b0;
        bus.data_rdata = 32'd0; bus.data_resp = 1'b0;

        #12;
        check("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
        check("rst_read", {31'd0, bus.data_read}, 32'd0);
        check("rst_write", {31'd0, bus.data_write}, 32'd0);
        check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        check("rst_err_tmo", {30'd0, bus.mem_err, bus.mem_timeout}, 32'd0);
        check("rst_addr", bus.data_addr, 32'd0);
        rst = 1'b0;
        tick();

        // ALU op
        push(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1);
        check("alu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        tick();
        check("alu_pulse_end", {31'd0, bus.wb_valid}, 32'd0);

        // ALU op to x0 never writes
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h5555, 5'd0, 1'b1);
        tick();

        // LB 0x103, response in the third request cycle
        push(1'b1, 5'd7, 32'hFFFF_FF80, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 32'h0, 5'd7, 1'b1);
        check("lb_read", {31'd0, bus.data_read}, 32'd1);
        check("lb_addr", bus.data_addr, 32'h100);
        check("lb_busy", {31'd0, bus.ex_ready}, 32'd0);
        tick();
        tick();
        check("lb_read_held", {31'd0, bus.data_read}, 32'd1);
        bus.data_resp = 1'b1; bus.data_rdata = 32'h80FF_FF7F;
        tick();
        bus.data_resp = 1'b0;
        check("lb_read_drop", {31'd0, bus.data_read}, 32'd0);
        check("lb_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        check("lb_ready", {31'd0, bus.ex_ready}, 32'd1);
        tick();

        // SH 0x22
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 3'd1, 32'h22, 32'hABCD, 32'h0, 5'd0, 1'b0);
        check("sh_write", {31'd0, bus.data_write}, 32'd1);
        check("sh_mbe", {28'd0, bus.data_mbe}, 32'hC);
        check("sh_wdata", bus.data_wdata, 32'hABCD_0000);
        tick();
        tick();
        check("sh_write_held", {31'd0, bus.data_write}, 32'd1);
        check("sh_mbe_held", {28'd0, bus.data_mbe}, 32'hC);
        bus.data_resp = 1'b1;
        tick();
        bus.data_resp = 1'b0;
        check("sh_write_drop", {31'd0, bus.data_write}, 32'd0);
        tick();

        // Load extraction patterns, immediate response
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 5'(10 + i), ld_exp[i], 1'b0, 1'b0);
            issue(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0, 32'h0, 5'(10 + i), 1'b1);
            check("ld_addr", bus.data_addr, {ld_addr[i][31:2], 2'b00});
            bus.data_resp = 1'b1; bus.data_rdata = ld_rdat[i];
            tick();
            bus.data_resp = 1'b0;
        end
        tick();

        // LW to x0: access happens, no write
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 5'd0, 1'b1);
        bus.data_resp = 1'b1; bus.data_rdata = 32'h1111_2222;
        tick();
        bus.data_resp = 1'b0;
        tick();

        // Store lanes
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
            issue(1'b0, 1'b1, st_f3[i], st_addr[i], st_dat[i], 32'h0, 5'd0, 1'b0);
            check("st_mbe", {28'd0, bus.data_mbe}, {28'd0, st_mbe[i]});
            check("st_wdata", bus.data_wdata, st_wd[i]);
            bus.data_resp = 1'b1;
            tick();
            bus.data_resp = 1'b0;
        end
        tick();

        // LW 0x101 misaligned
        push(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 5'd3, 1'b1);
        check("mis_no_read", {31'd0, bus.data_read}, 32'd0);
        check("mis_ready", {31'd0, bus.ex_ready}, 32'd1);
        check("mis_err", {31'd0, bus.mem_err}, 32'd1);
        tick();
        check("mis_err_end", {31'd0, bus.mem_err}, 32'd0);

        // Other misaligned / illegal encodings
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
            issue(er_ld[i], er_st[i], er_f3[i], er_addr[i], 32'h0, 32'h0, 5'd4, 1'b1);
            check("ill_no_req", {30'd0, bus.data_read, bus.data_write}, 32'd0);
        end
        tick();

        // Timeout: no response for MAX_WAIT request cycles
        push(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 5'd9, 1'b1);
        tick();
        tick();
        tick();
        check("tmo_read_4th", {31'd0, bus.data_read}, 32'd1);
        check("tmo_not_yet", {31'd0, bus.mem_timeout}, 32'd0);
        tick();
        check("tmo_read_drop", {31'd0, bus.data_read}, 32'd0);
        check("tmo_pulse", {31'd0, bus.mem_timeout}, 32'd1);
        check("tmo_ready", {31'd0, bus.ex_ready}, 32'd1);
        bus.data_resp = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
        tick();
        bus.data_resp = 1'b0;
        check("late_resp_ignored", {31'd0, bus.wb_valid}, 32'd0);
        tick();

        // Reset in the middle of a load
        issue(1'b1, 1'b0, 3'd2, 32'h300, 32'h0, 32'h0, 5'd6, 1'b1);
        check("rst_mid_read", {31'd0, bus.data_read}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_drop", {31'd0, bus.data_read}, 32'd0);
        check("rst_mid_ready", {31'd0, bus.ex_ready}, 32'd1);
        tick();
        check("rst_mid_no_wb", {31'd0, bus.wb_valid}, 32'd0);
        rst = 1'b0;
        tick();
        tick();

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
